// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: merges stage stall requests,
// sequences exception redirects around in-flight fetches, and counts stalls/flushes.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             ex_stall_req,
  input  logic             mem_stall_req,
  input  logic             exc_req,
  input  logic [31:0]      exc_target,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             busy_wait_if,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned PC_W = 32;

  typedef enum logic {
    S_RUN     = 1'b0,
    S_WAIT_IF = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_events_q, flush_events_d;
  logic              exc_accept;

  // Control outputs and next state; a D-cache miss blocks exception acceptance.
  always_comb begin
    stall_pc       = 1'b0;
    stall_if_id    = 1'b0;
    stall_id_ex    = 1'b0;
    stall_ex_mem   = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    flush_ex_mem   = 1'b0;
    flush_mem_wb   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    state_d        = state_q;
    target_d       = target_q;
    exc_accept     = exc_req && !mem_stall_req;

    unique case (state_q)
      S_RUN: begin
        if (exc_accept) begin
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          flush_mem_wb = 1'b1;
          redirect_pc  = exc_target;
          if (if_stall_req) begin
            target_d = exc_target;
            state_d  = S_WAIT_IF;
          end else begin
            redirect_valid = 1'b1;
          end
        end else if (mem_stall_req) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
          flush_mem_wb = 1'b1;
        end else if (ex_stall_req) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end else if (id_stall_req) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (if_stall_req) begin
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
        end
      end
      S_WAIT_IF: begin
        // Pipeline is already drained; only the stale fetch needs discarding.
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        target_d    = exc_accept ? exc_target : target_q;
        redirect_pc = target_d;
        if (!if_stall_req) begin
          redirect_valid = 1'b1;
          state_d        = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (rst) begin
      stall_pc       = 1'b0;
      stall_if_id    = 1'b0;
      stall_id_ex    = 1'b0;
      stall_ex_mem   = 1'b0;
      flush_if_id    = 1'b0;
      flush_id_ex    = 1'b0;
      flush_ex_mem   = 1'b0;
      flush_mem_wb   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end

    stall_cycles_d = stall_cycles_q + CNT_W'(stall_pc);
    flush_events_d = flush_events_q + CNT_W'(exc_accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_RUN;
      target_q       <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign busy_wait_if = (state_q == S_WAIT_IF);
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule
